p2_mem_write: RTL and testbench
===============================

# p2_mem_write

Write-side address generator and write-port driver for the pooling-layer-2 output memory. Accepts the stream of pooled results from the P2 pooling unit over a valid/ready handshake and writes each beat into the memory as 12 channels × 16 pixels (4×4 maps), raster order, channel-major. Signals frame completion so the downstream P2 memory reader (which sweeps the same 12×16 address space) can start.

## Interface
Parameters:
- DATA_W, 16, width of one pooled value / memory word
- CHANNELS, 12, number of 4×4 feature maps per frame (1..16)
- PIXELS, 16, words per feature map; fixed at 16 (4-bit pixel address)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse: clear counters and begin accepting a frame
- hold  in  1  memory-port stall; forces in_ready low while high
- in_valid  in  1  pooling unit has a beat on in_data
- in_data  in  DATA_W  pooled value
- in_ready  out  1  block can accept a beat this cycle
- we  out  1  memory write enable (registered)
- waddr  out  4  pixel address within current map, 0..15
- wchan  out  4  channel index, 0..CHANNELS-1
- mem_addr  out  8  flat address {wchan, waddr}
- wdata  out  DATA_W  data written with we
- busy  out  1  high in WRITE state
- done  out  1  frame fully written; sticky until start or reset
- overflow  out  1  sticky: beat offered after frame complete

## Operation
- States: IDLE, WRITE, DONE. Reset → IDLE.
- IDLE: in_ready=0. start → WRITE, beat counter cleared.
- WRITE: in_ready = ~hold. Accept = in_valid & in_ready at a rising edge.
  - On accept: register in_data into wdata, current pixel/channel counters into waddr/wchan, set we=1 for the next cycle; then advance pixel counter.
  - Pixel counter wraps 15→0 and increments channel counter on wrap.
  - On accepting the beat with pixel=15 and channel=CHANNELS-1: → DONE; counters not advanced further.
  - No accept in a cycle → we=0 next cycle; waddr/wchan/wdata hold their last value.
- DONE: in_ready=0, done=1, busy=0. in_valid=1 in DONE sets overflow (data dropped, no we). start → WRITE, clears done, overflow and counters.
- start while in WRITE: ignored (no restart mid-frame).
- start and in_valid in same cycle from IDLE/DONE: start wins; that beat is not accepted (in_ready was 0).
- hold only gates in_ready; it has no effect on the registered write already in flight.
- Reset mid-frame: all state cleared immediately; partially written frame abandoned, done=0.
- mem_addr = wchan*16 + waddr, i.e. concatenation; range 0..16·CHANNELS-1 (0..191 at default).

## Timing
- Reset values: in_ready=0, we=0, waddr=0, wchan=0, mem_addr=0, wdata=0, busy=0, done=0, overflow=0.
- start at edge N → busy=1 and in_ready=~hold from cycle N+1.
- Write latency: beat accepted at edge K → we/waddr/wchan/wdata valid in cycle after K (one cycle).
- Final accept at edge K → in_ready=0, done=1 and final we=1 all in cycle after K; we=0 from K+2.
- Max throughput: one beat per cycle; full frame minimum 16·CHANNELS cycles after first accept.
- in_ready depends combinationally on hold and state only, never on in_valid.

## Test plan
- Reset then start, in_valid held high, hold=0: 192 consecutive we pulses, mem_addr 0,1,…,191 in order, wdata matches in_data sequence; done rises with the final we (mem_addr=191, wchan=11, waddr=15).
- Random hold/in_valid gaps across a frame: exactly 192 writes, addresses strictly sequential, no writes during hold cycles, done only after beat 192.
- After done, drive in_valid=1 for 3 cycles: no we, in_ready=0, overflow=1; then start → overflow=0, done=0, next write at mem_addr=0.
- start pulsed at beat 50 of a frame: ignored; writes continue at mem_addr=50.
- Assert reset at beat 100: all outputs return to reset values asynchronously; after start the frame restarts at mem_addr=0.
- CHANNELS=3 build: done after 48 writes, last mem_addr=47 (wchan=2, waddr=15).

Source files
------------

// File: rtl/p2_mem_write.sv
// Write-side address generator for the pooling-layer-2 output memory.
// Takes one pooled beat per accept and writes it channel-major, 16 pixels per map.
module p2_mem_write #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CHANNELS = 12,
  parameter int unsigned PIXELS   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [3:0]        waddr,
  output logic [3:0]        wchan,
  output logic [7:0]        mem_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [3:0] LastPix  = 4'(PIXELS - 1);
  localparam logic [3:0] LastChan = 4'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        pix_q, pix_d;
  logic [3:0]        chan_q, chan_d;
  logic              overflow_q, overflow_d;
  logic              we_q;
  logic [3:0]        waddr_q, wchan_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              last_beat;
  logic              restart;

  assign accept    = in_valid & in_ready;
  assign last_beat = (pix_q == LastPix) && (chan_q == LastChan);
  // start is only honoured outside a frame; mid-frame pulses are ignored
  assign restart   = start & (state_q != StWrite);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrite;
      StWrite: if (accept && last_beat) state_d = StDone;
      StDone:  if (start) state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; in_ready never looks at in_valid
  always_comb begin
    in_ready = (state_q == StWrite) & ~hold;
    busy     = (state_q == StWrite);
    done     = (state_q == StDone);
  end

  // Pixel/channel counters and sticky overflow
  always_comb begin
    pix_d      = pix_q;
    chan_d     = chan_q;
    overflow_d = overflow_q;
    if (restart) begin
      pix_d      = '0;
      chan_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept && !last_beat) begin
        if (pix_q == LastPix) begin
          pix_d  = '0;
          chan_d = chan_q + 4'd1;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      if ((state_q == StDone) && in_valid) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q      <= '0;
      chan_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pix_q      <= pix_d;
      chan_q     <= chan_d;
      overflow_q <= overflow_d;
    end
  end

  // Registered write port; address/data hold their last value between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wchan_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        waddr_q <= pix_q;
        wchan_q <= chan_q;
        wdata_q <= in_data;
      end
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wchan    = wchan_q;
  assign wdata    = wdata_q;
  assign mem_addr = {wchan_q, waddr_q};
  assign overflow = overflow_q;

endmodule

// File: tb/tb_p2_mem_write.sv
// Directed bench for p2_mem_write: full frames, gaps/holds, overflow, ignored start, reset.
module tb_p2_mem_write;

  localparam int Beats = 192;

  logic        clk = 1'b0;
  logic        reset, start, hold, in_valid;
  logic [15:0] in_data;
  logic        in_ready, we, busy, done, overflow;
  logic [3:0]  waddr, wchan;
  logic [7:0]  mem_addr;
  logic [15:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side model
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  logic m_ovf  = 1'b0;
  int   m_addr = 0;

  p2_mem_write #(.DATA_W(16), .CHANNELS(12), .PIXELS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .hold     (hold),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wchan    (wchan),
    .mem_addr (mem_addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle; entered and left at posedge+1
  task automatic step(input logic v, input logic h, input logic [15:0] d, input logic st);
    logic old_busy, old_done, acc;
    int   ea;
    in_valid = v;
    hold     = h;
    in_data  = d;
    start    = st;
    @(negedge clk);
    old_busy = m_busy;
    old_done = m_done;
    chk("in_ready", in_ready, old_busy & ~h);
    acc = v & old_busy & ~h;
    ea  = m_addr;
    if (acc) begin
      m_addr++;
      if (m_addr == Beats) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    if (st && !old_busy) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_addr = 0;
    end else if (v && old_done) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("we", we, acc);
    if (acc) begin
      chk("mem_addr", mem_addr, ea);
      chk("wchan", wchan, ea / 16);
      chk("waddr", waddr, ea % 16);
      chk("wdata", wdata, d);
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wchan", wchan, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  initial begin
    int  cyc;
    logic pulsed;
    reset = 1'b1; start = 1'b0; hold = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;

    // Idle: beats offered are not taken and do not set overflow
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hdead, 1'b0);

    // Frame 1: streaming, no gaps
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < Beats; i++) step(1'b1, 1'b0, 16'h5000 + 16'(i), 1'b0);
    chk("f1_done", done, 1);
    chk("f1_last_addr", mem_addr, 191);

    // Overflow after done, then start wins over a same-cycle beat
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hbeef, 1'b0);
    chk("ovf_set", overflow, 1);
    step(1'b1, 1'b0, 16'hbad0, 1'b1);
    chk("ovf_clr", overflow, 0);

    // Frame 2: random gaps and holds, start pulse at beat 50 ignored
    cyc = 0;
    pulsed = 1'b0;
    while (m_busy && cyc < 4000) begin
      logic st;
      st = (m_addr == 50) && !pulsed;
      if (st) pulsed = 1'b1;
      step(($urandom % 4) != 0, ($urandom % 5) == 0, 16'($urandom), st);
      cyc++;
    end
    chk("f2_finished", m_busy, 0);
    chk("f2_done", done, 1);
    chk("f2_last_addr", mem_addr, 191);

    // Frame 3: reset at beat 100, then restart from address 0
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 16'h7000 + 16'(i), 1'b0);
    reset = 1'b1;
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_addr = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h9000 + 16'(i), 1'b0);
    chk("f3_restart_addr", mem_addr, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
